// File: rtl/apu_stereo_mixer.sv
// Stereo mixer for the APU output stage: sums the four channel DAC codes (plus
// optional VIN) one slot per clock, then applies the NR50 master volume per side.
module apu_stereo_mixer #(
  parameter int CODE_W = 4,
  parameter int VIN_EN = 1,
  localparam int OUT_W = CODE_W + 6
) (
  input  logic              apuv_4mhz,
  input  logic              apu_reset,
  input  logic              apu_on,
  input  logic              mix_start,
  input  logic [CODE_W-1:0] ch1_code,
  input  logic [CODE_W-1:0] ch2_code,
  input  logic [CODE_W-1:0] ch3_code,
  input  logic [CODE_W-1:0] ch4_code,
  input  logic              nch1_active,
  input  logic              nch2_active,
  input  logic              nch3_active,
  input  logic              nch4_active,
  input  logic [CODE_W-1:0] vin_code,
  input  logic [3:0]        lmixer,
  input  logic [3:0]        rmixer,
  input  logic [2:0]        nlvolume,
  input  logic [2:0]        nrvolume,
  input  logic              vin_l_ena,
  input  logic              vin_r_ena,
  output logic [OUT_W-1:0]  left_out,
  output logic [OUT_W-1:0]  right_out,
  output logic              sample_valid,
  output logic              busy
);

  localparam int N     = (VIN_EN != 0) ? 5 : 4;
  localparam int ACC_W = CODE_W + 3;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SCALE
  } state_t;

  state_t            state;
  logic [2:0]        slot;
  logic [ACC_W-1:0]  acc_l;
  logic [ACC_W-1:0]  acc_r;

  // Snapshot taken at the start edge; the sample in flight only ever sees these.
  logic [CODE_W-1:0] code_snap [5];
  logic [4:0]        l_en;
  logic [4:0]        r_en;
  logic [2:0]        lvol;
  logic [2:0]        rvol;

  logic [CODE_W-1:0] code_in [5];
  logic [3:0]        nact_in;
  logic [4:0]        l_en_in;
  logic [4:0]        r_en_in;

  assign code_in[0] = ch1_code;
  assign code_in[1] = ch2_code;
  assign code_in[2] = ch3_code;
  assign code_in[3] = ch4_code;
  assign code_in[4] = vin_code;
  assign nact_in    = {nch4_active, nch3_active, nch2_active, nch1_active};

  // A channel slot contributes only if routed to that side and its channel is running.
  logic [CODE_W-1:0] l_term [5];
  logic [CODE_W-1:0] r_term [5];

  for (genvar gi = 0; gi < 4; gi++) begin : g_chan
    assign l_en_in[gi] = lmixer[gi] & ~nact_in[gi];
    assign r_en_in[gi] = rmixer[gi] & ~nact_in[gi];
  end
  assign l_en_in[4] = (VIN_EN != 0) && vin_l_ena;
  assign r_en_in[4] = (VIN_EN != 0) && vin_r_ena;

  for (genvar gi = 0; gi < 5; gi++) begin : g_term
    assign l_term[gi] = l_en[gi] ? code_snap[gi] : '0;
    assign r_term[gi] = r_en[gi] ? code_snap[gi] : '0;
  end

  logic [CODE_W-1:0] l_add;
  logic [CODE_W-1:0] r_add;

  always_comb begin
    l_add = '0;
    r_add = '0;
    for (int k = 0; k < 5; k++) begin
      if (slot == 3'(k)) begin
        l_add = l_term[k];
        r_add = r_term[k];
      end
    end
  end

  // Multiply at full output width: the 4-bit (vol+1) factor times the
  // accumulator overflows the accumulator's own width.
  logic [3:0]       lfac;
  logic [3:0]       rfac;
  logic [OUT_W-1:0] l_scaled;
  logic [OUT_W-1:0] r_scaled;

  assign lfac     = {1'b0, lvol} + 4'd1;
  assign rfac     = {1'b0, rvol} + 4'd1;
  assign l_scaled = OUT_W'(acc_l) * OUT_W'(lfac);
  assign r_scaled = OUT_W'(acc_r) * OUT_W'(rfac);

  always_ff @(posedge apuv_4mhz or posedge apu_reset) begin
    if (apu_reset) begin
      state        <= IDLE;
      slot         <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      left_out     <= '0;
      right_out    <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      l_en         <= '0;
      r_en         <= '0;
      lvol         <= '0;
      rvol         <= '0;
      for (int k = 0; k < 5; k++) code_snap[k] <= '0;
    end else if (!apu_on) begin
      // Master off aborts any sample in flight without a valid pulse.
      state        <= IDLE;
      slot         <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      left_out     <= '0;
      right_out    <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (mix_start) begin
            for (int k = 0; k < 5; k++) code_snap[k] <= code_in[k];
            l_en  <= l_en_in;
            r_en  <= r_en_in;
            lvol  <= ~nlvolume;
            rvol  <= ~nrvolume;
            acc_l <= '0;
            acc_r <= '0;
            slot  <= '0;
            busy  <= 1'b1;
            state <= ACC;
          end
        end
        ACC: begin
          acc_l <= acc_l + ACC_W'(l_add);
          acc_r <= acc_r + ACC_W'(r_add);
          slot  <= slot + 3'd1;
          if (slot == 3'(N - 1)) begin
            state <= SCALE;
          end
        end
        SCALE: begin
          left_out     <= l_scaled;
          right_out    <= r_scaled;
          sample_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apu_stereo_mixer.sv
// Scoreboard bench for apu_stereo_mixer: stimulus pushes expected samples,
// an independent monitor pops and checks them whenever sample_valid pulses.
module tb_apu_stereo_mixer;

  logic       clk = 1'b0;
  logic       apu_reset;
  logic       apu_on;
  logic       mix_start;
  logic [3:0] code [4];
  logic [3:0] nact;
  logic [3:0] vin;
  logic [3:0] lmix;
  logic [3:0] rmix;
  logic [2:0] nl;
  logic [2:0] nr;
  logic       vl;
  logic       vr;
  logic [9:0] left_out;
  logic [9:0] right_out;
  logic       sample_valid;
  logic       busy;

  always #5 clk = ~clk;

  apu_stereo_mixer dut (
    .apuv_4mhz   (clk),
    .apu_reset   (apu_reset),
    .apu_on      (apu_on),
    .mix_start   (mix_start),
    .ch1_code    (code[0]),
    .ch2_code    (code[1]),
    .ch3_code    (code[2]),
    .ch4_code    (code[3]),
    .nch1_active (nact[0]),
    .nch2_active (nact[1]),
    .nch3_active (nact[2]),
    .nch4_active (nact[3]),
    .vin_code    (vin),
    .lmixer      (lmix),
    .rmixer      (rmix),
    .nlvolume    (nl),
    .nrvolume    (nr),
    .vin_l_ena   (vl),
    .vin_r_ena   (vr),
    .left_out    (left_out),
    .right_out   (right_out),
    .sample_valid(sample_valid),
    .busy        (busy)
  );

  typedef struct {
    int l;
    int r;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: volume = 7 - n (active-low), scale factor volume+1.
  function automatic exp_t model();
    exp_t e;
    int l = 0;
    int r = 0;
    for (int k = 0; k < 4; k++) begin
      if (lmix[k] && !nact[k]) l += int'(code[k]);
      if (rmix[k] && !nact[k]) r += int'(code[k]);
    end
    if (vl) l += int'(vin);
    if (vr) r += int'(vin);
    e.l   = l * (8 - int'(nl));
    e.r   = r * (8 - int'(nr));
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: every valid pulse must match the oldest expected sample.
  always @(negedge clk) begin
    exp_t e;
    if (!apu_reset && sample_valid) begin
      check("busy_with_valid", int'(busy), 0);
      if (q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_valid: got L=%0d R=%0d expected no sample (cycle %0d)",
                 left_out, right_out, cyc);
      end else begin
        e = q.pop_front();
        check("left_out", int'(left_out), e.l);
        check("right_out", int'(right_out), e.r);
        check("latency", cyc, e.cyc);
        $display("[TB] sample L=%0d R=%0d expL=%0d expR=%0d cyc=%0d", left_out, right_out, e.l, e.r, cyc);
      end
    end
  end

  task automatic mute();
    for (int k = 0; k < 4; k++) code[k] = 4'd0;
    nact = 4'hF;
    vin  = 4'd0;
    lmix = 4'h0;
    rmix = 4'h0;
    nl   = 3'd7;
    nr   = 3'd7;
    vl   = 1'b0;
    vr   = 1'b0;
  endtask

  task automatic set_random();
    for (int k = 0; k < 4; k++) code[k] = 4'($urandom);
    nact = 4'($urandom) & 4'($urandom);
    vin  = 4'($urandom);
    lmix = 4'($urandom);
    rmix = 4'($urandom);
    nl   = 3'($urandom);
    nr   = 3'($urandom);
    vl   = 1'($urandom);
    vr   = 1'($urandom);
  endtask

  task automatic set_full();
    for (int k = 0; k < 4; k++) code[k] = 4'd15;
    nact = 4'h0;
    lmix = 4'hF;
    rmix = 4'hF;
    nl   = 3'd0;
    nr   = 3'd0;
    vl   = 1'b0;
    vr   = 1'b0;
    vin  = 4'd15;
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start(input bit push, input bit use_model, input int el, input int er);
    exp_t e;
    if (use_model) e = model();
    else begin
      e.l = el;
      e.r = er;
    end
    mix_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mix_start = 1'b0;
    if (push) begin
      e.cyc = cyc + 6;
      q.push_back(e);
    end
  endtask

  initial begin
    apu_reset = 1'b1;
    apu_on    = 1'b1;
    mix_start = 1'b0;
    mute();
    repeat (3) @(negedge clk);
    check("reset_left", int'(left_out), 0);
    check("reset_right", int'(right_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(sample_valid), 0);
    apu_reset = 1'b0;
    @(negedge clk);

    // Full-scale sum with 8x volume, VIN off.
    set_full();
    start(1, 0, 480, 480);
    check("busy_in_acc", int'(busy), 1);
    repeat (6) @(negedge clk);
    check("busy_after_sample", int'(busy), 0);
    repeat (2) @(negedge clk);

    // Routing and volume.
    mute();
    code[0] = 4'd5;  nact[0] = 1'b0; lmix = 4'b0001;
    code[1] = 4'd3;  nact[1] = 1'b0; rmix = 4'b0010;
    nl = 3'b111; nr = 3'b100;
    start(1, 0, 5, 12);
    set_random();
    repeat (8) @(negedge clk);

    // Inactive channel is excluded even when routed.
    mute();
    code[2] = 4'd15; nact = 4'b1110; code[0] = 4'd2;
    lmix = 4'hF; rmix = 4'hF;
    start(1, 0, 2, 2);
    repeat (8) @(negedge clk);

    // VIN slot routed to the left only.
    mute();
    vin = 4'd9; vl = 1'b1; vr = 1'b0; nl = 3'b110;
    start(1, 0, 18, 0);
    repeat (8) @(negedge clk);

    // Load a non-zero held sample, then reset during ACC slot 2.
    set_full();
    start(1, 0, 480, 480);
    repeat (8) @(negedge clk);
    start(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    apu_reset = 1'b1;
    #1;
    check("midreset_left", int'(left_out), 0);
    check("midreset_right", int'(right_out), 0);
    check("midreset_busy", int'(busy), 0);
    @(negedge clk);
    apu_reset = 1'b0;
    @(negedge clk);
    start(1, 0, 480, 480);
    repeat (8) @(negedge clk);

    // Second start while busy is ignored.
    set_random();
    start(1, 1, 0, 0);
    set_random();
    mix_start = 1'b1;
    @(negedge clk);
    mix_start = 1'b0;
    repeat (14) @(negedge clk);

    // apu_on dropped in SCALE: no valid, held outputs cleared.
    set_full();
    start(1, 0, 480, 480);
    repeat (8) @(negedge clk);
    start(0, 0, 0, 0);
    repeat (5) @(negedge clk);
    apu_on = 1'b0;
    @(negedge clk);
    check("abort_valid", int'(sample_valid), 0);
    check("abort_left", int'(left_out), 0);
    check("abort_right", int'(right_out), 0);
    check("abort_busy", int'(busy), 0);

    // Start with apu_on low never goes busy.
    mix_start = 1'b1;
    @(negedge clk);
    mix_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("off_busy", int'(busy), 0);
      @(negedge clk);
    end
    apu_on = 1'b1;
    repeat (2) @(negedge clk);

    // Random back-to-back samples; inputs scrambled after each start edge.
    for (int i = 0; i < 40; i++) begin
      set_random();
      start(1, 1, 0, 0);
      set_random();
      repeat (6 + $urandom_range(0, 2)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    check("drain_queue", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
